// File: rtl/hbridge_sequencer.sv
// H-bridge gate sequencer: coast/brake, dead-time on start-up and reversal,
// and PWM on the active high-side switch. Every output is a register.
module hbridge_sequencer #(
  parameter int PWM_BITS        = 8,
  parameter int DEADTIME_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                direction,
  input  logic                brake,
  input  logic [PWM_BITS-1:0] duty,
  output logic                INA,
  output logic                INB,
  output logic                INC,
  output logic                IND,
  output logic                running,
  output logic                active_dir,
  output logic                pwm_sync
);

  localparam logic [PWM_BITS-1:0] CNT_MAX   = '1;
  localparam logic [15:0]         DEAD_LOAD = 16'(DEADTIME_CYCLES - 1);

  typedef enum logic [1:0] {S_OFF, S_DEAD, S_DRIVE} state_t;

  state_t                state_q, state_d;
  logic [PWM_BITS-1:0]   cnt_q, cnt_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic [15:0]           dead_q, dead_d;
  logic                  target_q, target_d;
  logic                  active_q, active_d;
  logic [3:0]            gates_q, gates_d;
  logic                  run_q, run_d;
  logic                  sync_q, sync_d;
  logic                  pwm_on;

  // All-ones duty is full on; otherwise high while the counter is below duty.
  function automatic logic pwm_on_f(input logic [PWM_BITS-1:0] c,
                                    input logic [PWM_BITS-1:0] d);
    return (d == CNT_MAX) || (c < d);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_OFF;
      cnt_q    <= '0;
      duty_q   <= '0;
      dead_q   <= '0;
      target_q <= 1'b0;
      active_q <= 1'b0;
      gates_q  <= 4'b0000;
      run_q    <= 1'b0;
      sync_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      dead_q   <= dead_d;
      target_q <= target_d;
      active_q <= active_d;
      gates_q  <= gates_d;
      run_q    <= run_d;
      sync_q   <= sync_d;
    end
  end

  // Duty is captured on the last count so a new value starts cleanly at cnt==0.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    duty_d = (cnt_q == CNT_MAX) ? duty : duty_q;
  end

  always_comb begin
    state_d  = state_q;
    dead_d   = dead_q;
    target_d = target_q;
    active_d = active_q;
    case (state_q)
      S_OFF: begin
        if (enable && !brake) begin
          state_d  = S_DEAD;
          dead_d   = DEAD_LOAD;
          target_d = direction;
        end
      end
      S_DEAD: begin
        if (brake || !enable) begin
          state_d = S_OFF;
        end else if (direction != target_q) begin
          target_d = direction;
          dead_d   = DEAD_LOAD;
        end else if (dead_q == 16'd0) begin
          state_d  = S_DRIVE;
          active_d = target_q;
        end else begin
          dead_d = dead_q - 16'd1;
        end
      end
      S_DRIVE: begin
        if (brake || !enable) begin
          state_d = S_OFF;
        end else if (direction != active_q) begin
          state_d  = S_DEAD;
          dead_d   = DEAD_LOAD;
          target_d = direction;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  // Outputs are computed from next-state values so they register in step with the FSM.
  always_comb begin
    pwm_on  = pwm_on_f(cnt_d, duty_d);
    gates_d = 4'b0000;
    run_d   = (state_d == S_DRIVE);
    sync_d  = (cnt_d == '0);
    if (state_d == S_DRIVE) begin
      if (active_d) gates_d = {pwm_on, 1'b0, 1'b0, 1'b1};
      else          gates_d = {1'b0, 1'b1, pwm_on, 1'b0};
    end
  end

  assign {INA, INB, INC, IND} = gates_q;
  assign running    = run_q;
  assign active_dir = active_q;
  assign pwm_sync   = sync_q;

endmodule

// File: tb/tb_hbridge_sequencer.sv
// Directed bench for hbridge_sequencer: dead-time, reversal, brake, duty
// latching and asynchronous reset, with shoot-through checks every cycle.
module tb_hbridge_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       direction;
  logic       brake;
  logic [7:0] duty;
  logic       INA, INB, INC, IND;
  logic       running, active_dir, pwm_sync;

  int         total = 0;
  int         bad   = 0;
  int         cnt_m = 0;
  logic [7:0] dl_m  = 8'd0;

  hbridge_sequencer #(.PWM_BITS(8), .DEADTIME_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .direction(direction),
    .brake(brake), .duty(duty), .INA(INA), .INB(INB), .INC(INC), .IND(IND),
    .running(running), .active_dir(active_dir), .pwm_sync(pwm_sync)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pwm_m(input int c, input logic [7:0] d);
    return (d == 8'hFF) ? 1'b1 : (c < int'(d));
  endfunction

  // One clock: the duty model latches on the wrap edge, then outputs are sampled after it.
  task automatic tick();
    if (cnt_m == 255) dl_m = duty;
    @(posedge clk);
    #1;
    cnt_m = (cnt_m + 1) % 256;
    check("leg1_shoot", {31'd0, INA & INB}, 32'd0);
    check("leg2_shoot", {31'd0, INC & IND}, 32'd0);
    check("both_high",  {31'd0, INA & INC}, 32'd0);
  endtask

  task automatic expect_dead(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, {27'd0, INA, INB, INC, IND, running}, 32'd0);
    end
  endtask

  task automatic expect_drive(input int n, input logic dir, input string tag);
    logic p;
    for (int i = 0; i < n; i++) begin
      tick();
      p = pwm_m(cnt_m, dl_m);
      if (dir) check(tag, {27'd0, INA, INB, INC, IND, running}, {27'd0, p, 1'b0, 1'b0, 1'b1, 1'b1});
      else     check(tag, {27'd0, INA, INB, INC, IND, running}, {27'd0, 1'b0, 1'b1, p, 1'b0, 1'b1});
      check({tag, "_dir"},  {31'd0, active_dir}, {31'd0, dir});
      check({tag, "_sync"}, {31'd0, pwm_sync}, {31'd0, cnt_m == 0});
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; direction = 1'b0; brake = 1'b0; duty = 8'd0;
    #12;
    check("reset_outs", {25'd0, INA, INB, INC, IND, running, active_dir, pwm_sync}, 32'd0);

    // Start-up forward at 50% duty; the first period still uses the reset duty of 0.
    @(negedge clk);
    reset = 1'b0; enable = 1'b1; direction = 1'b1; duty = 8'd128;
    cnt_m = 0; dl_m = 8'd0;
    expect_dead(16, "start_dead");
    expect_drive(300, 1'b1, "fwd_drive");

    // Reversal
    direction = 1'b0;
    expect_dead(16, "rev_dead");
    expect_drive(40, 1'b0, "rev_drive");

    // Toggle during dead-time restarts the full interval
    direction = 1'b1;
    expect_dead(8, "toggle_dead_a");
    direction = 1'b0;
    expect_dead(16, "toggle_dead_b");
    expect_drive(20, 1'b0, "toggle_drive");

    // One-cycle brake, then full dead-time on release
    brake = 1'b1;
    expect_dead(1, "brake");
    check("brake_hold_dir", {31'd0, active_dir}, 32'd0);
    brake = 1'b0;
    expect_dead(16, "brake_release_dead");
    expect_drive(10, 1'b0, "brake_resume");

    // Duty updates only at the period wrap
    direction = 1'b1; duty = 8'd64;
    expect_dead(16, "duty_dead");
    expect_drive(300, 1'b1, "duty64");
    while (cnt_m != 100) expect_drive(1, 1'b1, "duty64_wait");
    duty = 8'd200;
    tick();
    check("duty_midperiod_ina", {31'd0, INA}, 32'd0);
    expect_drive(400, 1'b1, "duty200");
    duty = 8'd255;
    expect_drive(300, 1'b1, "duty255");
    check("duty255_ina", {31'd0, INA}, 32'd1);
    duty = 8'd0;
    expect_drive(300, 1'b1, "duty0");
    check("duty0_ina_ind", {30'd0, INA, IND}, 32'd1);

    // Asynchronous reset between edges
    #2 reset = 1'b1;
    #1;
    check("async_reset", {26'd0, INA, INB, INC, IND, running, pwm_sync}, 32'd0);
    #1 reset = 1'b0;
    cnt_m = 0; dl_m = 8'd0;
    expect_dead(16, "post_reset_dead");
    expect_drive(5, 1'b1, "post_reset_drive");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hbridge_sequencer.md
Name: hbridge_sequencer

Overview:
- Registered controller for the four H-bridge gate inputs INA..IND.
- Sequences coast/brake, enforced dead-time on start-up and direction reversal, and PWM drive of the high-side switch.
- Sits between the motor command logic (direction, brake, enable, duty) and the bridge pins.
- Guarantees no leg ever has high-side and low-side on together.

Parameters:
- PWM_BITS, 8, width of duty input and PWM period counter; period = 2^PWM_BITS clocks.
- DEADTIME_CYCLES, 16, clocks with all outputs low before any drive after start or reversal; legal range 1..65535.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  drive permitted when high.
- direction  input  1  requested direction; 1 = forward, 0 = reverse.
- brake  input  1  high forces all gate outputs low (coast), overriding everything except reset.
- duty  input  PWM_BITS  requested duty; sampled only at PWM period wrap.
- INA  output  1  leg-1 high side.
- INB  output  1  leg-1 low side.
- INC  output  1  leg-2 high side.
- IND  output  1  leg-2 low side.
- running  output  1  high while in DRIVE.
- active_dir  output  1  direction currently driven; valid when running=1.
- pwm_sync  output  1  one-cycle pulse on the clock where the PWM counter wraps to 0.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values:
  - INA..IND=0, running=0, active_dir=0, pwm_sync=0.
  - State=OFF, PWM counter=0, latched duty=0, dead-time counter=0, target_dir=0.
- All outputs are registers. An input change visible before rising edge N is reflected on outputs after edge N (1-cycle latency).
- PWM:
  - Free-running counter cnt, 0..2^PWM_BITS-1, wraps to 0. Runs in every state; reset only by reset.
  - duty is latched when cnt == max, so it takes effect when cnt returns to 0. This gives glitch-free duty updates.
  - pwm_on = (cnt < duty_latched). Special case: duty_latched all-ones gives pwm_on = 1 (100%). duty_latched = 0 gives always off.
  - pwm_sync = 1 for the cycle in which cnt == 0.
- States:
  - OFF: outputs all 0.
    - enable=1 and brake=0 → DEAD; load dead counter = DEADTIME_CYCLES-1; target_dir = direction.
  - DEAD: outputs all 0.
    - brake=1 or enable=0 → OFF.
    - direction != target_dir → target_dir = direction; reload counter to DEADTIME_CYCLES-1 (restart).
    - counter == 0 → DRIVE; active_dir = target_dir.
    - Otherwise decrement.
  - DRIVE:
    - Forward: INA = pwm_on, IND = 1, INB = INC = 0.
    - Reverse: INC = pwm_on, INB = 1, INA = IND = 0.
    - brake=1 or enable=0 → OFF.
    - direction != active_dir → DEAD (load counter, target_dir = direction).
- Priority within a cycle: reset > brake > !enable > direction change > counter expiry.
- Dead-time: exactly DEADTIME_CYCLES consecutive all-zero output cycles between leaving DRIVE or OFF and the first DRIVE output cycle.
- Entering DRIVE does not resynchronise the PWM counter. The first drive cycle uses the current cnt.
- Invariants, checked every cycle:
  - !(INA & INB) and !(INC & IND).
  - Never both legs driving high side.
  - Outputs never change from one drive pattern to the opposite one without passing through DEAD.
- Brake release from OFF always passes through full dead-time. Brake is never a shortcut into DRIVE.
- Reset mid-DRIVE or mid-DEAD: outputs go to 0 asynchronously; FSM restarts in OFF.
- running = (state == DRIVE). active_dir holds its last value outside DRIVE.

Test Plan:
- Reset, then enable=1, direction=1, duty=128, DEADTIME_CYCLES=16 → all outputs 0 for 16 clocks, then IND=1 and INA high for cnt<128 each period, running=1, active_dir=1.
- In forward DRIVE, set direction=0 → next edge all outputs 0 for 16 clocks; then INB=1, INC=pwm_on, active_dir=0; no cycle has INA&INB or INC&IND.
- During DEAD (after 8 clocks), toggle direction back to 1 → counter restarts; 16 further zero cycles, then forward drive.
- In DRIVE, assert brake for 1 clock → outputs 0 after the same edge, running=0; on release, 16-cycle dead-time before drive resumes.
- Change duty 64→200 mid-period → INA high-time stays 64 for the current period; 200 from the cycle after pwm_sync. duty=255 gives INA constant 1; duty=0 gives INA constant 0 with IND=1.
- Assert reset asynchronously mid-DRIVE (between edges) → INA..IND=0 immediately; after release, state OFF with full dead-time on next enable.
